// File: rtl/cpu_step_ctrl.sv
// Clock-enable generator for the TD-series soft CPUs: free-run divider, debounced
// single-step key, or halt. Also exports the debounced key and a CE pulse counter.
module cpu_step_ctrl #(
  parameter int DIV_W  = 28,
  parameter int DEB_W  = 16,
  parameter int STEP_W = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              KEY,
  input  logic [1:0]        MODE,
  input  logic [4:0]        RATE,
  output logic              CE,
  output logic              KEY_LEVEL,
  output logic              KEY_PRESS,
  output logic [STEP_W-1:0] STEP_CNT,
  output logic              HALTED
);

  localparam int RATE_W = (DIV_W > 1) ? $clog2(DIV_W) : 1;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_STEP = 2'b01,
    MODE_HALT = 2'b10,
    MODE_RUN2 = 2'b11
  } mode_e;

  logic              key_s1, key_s2, key_stable;
  logic [DEB_W-1:0]  deb_cnt;
  logic              deb_flip;
  logic              key_press_q;
  mode_e             mode_q;
  logic [RATE_W-1:0] rate_q, rate_clamp;
  logic [DIV_W-1:0]  divider, divider_next;
  logic              tap_prev, tap_prev_next;
  logic              clear_edge, ce_next, ce_q;
  logic [STEP_W-1:0] step_cnt;

  // The debounced level flips only after s2 has disagreed for a full counter span.
  assign deb_flip = (key_s2 != key_stable) && (deb_cnt == {DEB_W{1'b1}});

  always_comb begin
    rate_clamp = (int'(RATE) >= DIV_W) ? RATE_W'(DIV_W - 1) : RATE_W'(RATE);
    clear_edge = (MODE != mode_q) || (rate_clamp != rate_q);
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    divider_next  = divider;
    tap_prev_next = tap_prev;
    ce_next       = 1'b0;
    if (clear_edge) begin
      divider_next  = '0;
      tap_prev_next = 1'b0;
    end else begin
      unique case (mode_q)
        MODE_STEP: begin
          divider_next  = '0;
          tap_prev_next = 1'b0;
          ce_next       = key_press_q;
        end
        MODE_HALT: begin
        end
        default: begin
          // A held key pauses free-run; release restarts as from a clear edge.
          if (!key_stable) begin
            divider_next  = '0;
            tap_prev_next = 1'b0;
          end else begin
            divider_next  = divider + DIV_W'(1);
            tap_prev_next = divider[rate_q];
            ce_next       = divider[rate_q] & ~tap_prev;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      key_s1      <= 1'b1;
      key_s2      <= 1'b1;
      key_stable  <= 1'b1;
      deb_cnt     <= '0;
      key_press_q <= 1'b0;
      mode_q      <= MODE_RUN;
      rate_q      <= '0;
      divider     <= '0;
      tap_prev    <= 1'b0;
      ce_q        <= 1'b0;
      step_cnt    <= '0;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
      if (key_s2 == key_stable) begin
        deb_cnt <= '0;
      end else if (deb_flip) begin
        key_stable <= key_s2;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
      key_press_q <= deb_flip & ~key_s2;
      mode_q      <= mode_e'(MODE);
      rate_q      <= rate_clamp;
      divider     <= divider_next;
      tap_prev    <= tap_prev_next;
      ce_q        <= ce_next;
      step_cnt    <= step_cnt + STEP_W'(ce_next);
    end
  end

  assign CE        = ce_q;
  assign KEY_LEVEL = ~key_stable;
  assign KEY_PRESS = key_press_q;
  assign STEP_CNT  = step_cnt;
  assign HALTED    = (mode_q == MODE_HALT);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl (DIV_W=8, DEB_W=4, STEP_W=8): expected CE and
// KEY_PRESS edges are queued as stimulus is driven and compared every cycle.
module tb_cpu_step_ctrl;

  logic       clk;
  logic       RESET;
  logic       KEY;
  logic [1:0] MODE;
  logic [4:0] RATE;
  logic       CE;
  logic       KEY_LEVEL;
  logic       KEY_PRESS;
  logic [7:0] STEP_CNT;
  logic       HALTED;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int exp_step = 0;

  typedef struct packed {
    int edge_no;
    int step;
  } ce_exp_t;

  ce_exp_t ce_q[$];
  int      press_q[$];

  cpu_step_ctrl #(
    .DIV_W (8),
    .DEB_W (4),
    .STEP_W(8)
  ) dut (
    .CLOCK    (clk),
    .RESET    (RESET),
    .KEY      (KEY),
    .MODE     (MODE),
    .RATE     (RATE),
    .CE       (CE),
    .KEY_LEVEL(KEY_LEVEL),
    .KEY_PRESS(KEY_PRESS),
    .STEP_CNT (STEP_CNT),
    .HALTED   (HALTED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_edge(input int target);
    while (edge_n < target) @(negedge clk);
  endtask

  task automatic exp_ce(input int e);
    ce_exp_t item;
    exp_step     = (exp_step + 1) % 256;
    item.edge_no = e;
    item.step    = exp_step;
    ce_q.push_back(item);
  endtask

  // Every cycle: CE must be high exactly on queued edges, with the queued count.
  always @(negedge clk) begin : ce_monitor
    ce_exp_t head;
    bit      due;
    due = (ce_q.size() > 0) && (ce_q[0].edge_no == edge_n);
    check("ce", 32'(CE), 32'(due));
    if (due) begin
      head = ce_q.pop_front();
      check("ce_step_cnt", 32'(STEP_CNT), 32'(head.step));
    end
  end

  always @(negedge clk) begin : press_monitor
    bit due;
    due = (press_q.size() > 0) && (press_q[0] == edge_n);
    check("key_press", 32'(KEY_PRESS), 32'(due));
    if (due) void'(press_q.pop_front());
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    int r, e, c, c2, p, q;
    RESET = 1'b1;
    KEY   = 1'b0;
    MODE  = 2'b10;
    RATE  = 5'd2;
    tick(3);
    check("reset_ce", 32'(CE), 0);
    check("reset_key_level", 32'(KEY_LEVEL), 0);
    check("reset_key_press", 32'(KEY_PRESS), 0);
    check("reset_step_cnt", 32'(STEP_CNT), 0);
    check("reset_halted", 32'(HALTED), 0);

    // Release reset with the key held: press seen 18 edges later, ignored in HALT.
    RESET = 1'b0;
    r = edge_n;
    press_q.push_back(r + 18);
    tick(1);
    check("halted_one_edge", 32'(HALTED), 1);
    wait_edge(r + 17);
    check("key_level_before", 32'(KEY_LEVEL), 0);
    wait_edge(r + 18);
    check("key_level_after", 32'(KEY_LEVEL), 1);
    KEY = 1'b1;
    tick(25);
    check("key_released", 32'(KEY_LEVEL), 0);

    // RUN at RATE=2: first CE 5 edges after the clear edge, then every 8.
    MODE = 2'b00;
    e = edge_n + 1;
    exp_ce(e + 5);
    exp_ce(e + 13);
    exp_ce(e + 21);
    wait_edge(e + 22);
    check("run_step_cnt", 32'(STEP_CNT), 3);

    // HALT 500 cycles with a press in the middle: reported, never stepped.
    MODE = 2'b10;
    tick(10);
    p = edge_n;
    KEY = 1'b0;
    press_q.push_back(p + 18);
    tick(25);
    KEY = 1'b1;
    tick(465);
    check("halt_halted", 32'(HALTED), 1);
    check("halt_step_cnt", 32'(STEP_CNT), 3);

    // Back to RUN, then rate changes mid-run, clamp of 9 to 7, and 9->7 is no change.
    MODE = 2'b00;
    e = edge_n + 1;
    exp_ce(e + 5);
    exp_ce(e + 13);
    wait_edge(e + 14);
    check("run_halted_clear", 32'(HALTED), 0);
    RATE = 5'd3;
    c = edge_n + 1;
    exp_ce(c + 9);
    exp_ce(c + 25);
    wait_edge(c + 26);
    RATE = 5'd9;
    c2 = edge_n + 1;
    exp_ce(c2 + 129);
    exp_ce(c2 + 385);
    wait_edge(c2 + 386);
    RATE = 5'd7;
    exp_ce(c2 + 641);
    wait_edge(c2 + 642);
    check("rate_step_cnt", 32'(STEP_CNT), 10);

    // STEP: clean press, bounced press, too-short press, long hold.
    MODE = 2'b01;
    tick(2);
    p = edge_n;
    KEY = 1'b0;
    press_q.push_back(p + 18);
    exp_ce(p + 19);
    tick(20);
    KEY = 1'b1;
    tick(30);

    KEY = 1'b0;
    tick(10);
    KEY = 1'b1;
    tick(3);
    q = edge_n;
    KEY = 1'b0;
    press_q.push_back(q + 18);
    exp_ce(q + 19);
    tick(20);
    KEY = 1'b1;
    tick(30);

    KEY = 1'b0;
    tick(12);
    KEY = 1'b1;
    tick(30);
    check("short_press_level", 32'(KEY_LEVEL), 0);

    p = edge_n;
    KEY = 1'b0;
    press_q.push_back(p + 18);
    exp_ce(p + 19);
    tick(1000);
    check("held_level", 32'(KEY_LEVEL), 1);
    KEY = 1'b1;
    tick(30);
    check("step_step_cnt", 32'(STEP_CNT), 13);

    // Mode change on the edge after KEY_PRESS: the clear edge swallows the step.
    p = edge_n;
    KEY = 1'b0;
    press_q.push_back(p + 18);
    wait_edge(p + 18);
    MODE = 2'b10;
    tick(5);
    KEY = 1'b1;
    tick(30);
    check("lost_press_step_cnt", 32'(STEP_CNT), 13);

    // RUN at RATE=0: 245 pulses carry STEP_CNT through 255 -> 0 and on to 2.
    MODE = 2'b00;
    RATE = 5'd0;
    e = edge_n + 1;
    for (int i = 1; i <= 245; i++) exp_ce(e + 2 * i);
    wait_edge(e + 490);
    MODE = 2'b10;
    tick(5);
    check("wrap_step_cnt", 32'(STEP_CNT), 2);

    check("ce_queue_drained", 32'(ce_q.size()), 0);
    check("press_queue_drained", 32'(press_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
